// File: rtl/jogo_sequencias_param.sv
// rtl/jogo_sequencias_param.sv - sequence memory game: LFSR-generated rounds, LED playback, player input, timeout
module jogo_sequencias_param #(
  parameter int          N_BOTOES       = 4,
  parameter int          PROFUNDIDADE   = 16,
  parameter int          TIMEOUT_CICLOS = 5000,
  parameter int          MOSTRA_CICLOS  = 500,
  parameter logic [15:0] SEMENTE        = 16'hACE1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          jogar,
  input  logic                          modo,
  input  logic [N_BOTOES-1:0]           botoes,
  output logic [N_BOTOES-1:0]           leds,
  output logic                          pronto,
  output logic                          ganhou,
  output logic                          perdeu,
  output logic                          timeout,
  output logic [$clog2(PROFUNDIDADE):0] db_rodada,
  output logic [3:0]                    db_estado
);
  localparam int AW = $clog2(PROFUNDIDADE);
  localparam int RW = AW + 1;
  localparam int EW = $clog2(N_BOTOES);
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  localparam int MW = $clog2(MOSTRA_CICLOS + 1);

  localparam logic [3:0] S_INICIAL   = 4'd0;
  localparam logic [3:0] S_PREPARA   = 4'd1;
  localparam logic [3:0] S_GERA      = 4'd2;
  localparam logic [3:0] S_MOSTRA    = 4'd3;
  localparam logic [3:0] S_INTERVALO = 4'd4;
  localparam logic [3:0] S_ESPERA    = 4'd5;
  localparam logic [3:0] S_COMPARA   = 4'd6;
  localparam logic [3:0] S_PROXIMA   = 4'd7;
  localparam logic [3:0] S_GANHOU    = 4'd8;
  localparam logic [3:0] S_PERDEU    = 4'd9;
  localparam logic [3:0] S_ESGOTOU   = 4'd10;

  logic [3:0]          state_q, state_d;
  logic                modo_q;
  logic [15:0]         lfsr_q;
  logic [RW-1:0]       round_q;
  logic [AW-1:0]       addr_q;
  logic [MW-1:0]       cnt_q;
  logic [TW-1:0]       tmo_q;
  logic                pressed_q;
  logic [N_BOTOES-1:0] jogada_q;
  logic [EW-1:0]       mem_q [PROFUNDIDADE];

  logic [RW-1:0]       round_m1, limite;
  logic [EW-1:0]       elem;
  logic [N_BOTOES-1:0] alvo;
  logic                ultimo, fim_cnt, jogada, esgotou, inicia, fb;

  assign round_m1 = round_q - RW'(1);
  assign limite   = modo_q ? RW'(PROFUNDIDADE) : RW'(PROFUNDIDADE / 2);
  assign ultimo   = ({1'b0, addr_q} == round_m1);
  assign fim_cnt  = (cnt_q == MW'(MOSTRA_CICLOS - 1));
  assign esgotou  = (tmo_q == TW'(TIMEOUT_CICLOS - 1));
  assign jogada   = (state_q == S_ESPERA) && (|botoes) && !pressed_q;
  assign inicia   = jogar && (state_q == S_INICIAL || state_q == S_GANHOU ||
                              state_q == S_PERDEU  || state_q == S_ESGOTOU);
  assign elem     = EW'(lfsr_q[7:0] % 8'(N_BOTOES));
  assign fb       = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign alvo     = N_BOTOES'(1) << mem_q[addr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INICIAL, S_GANHOU, S_PERDEU, S_ESGOTOU: if (inicia) state_d = S_PREPARA;
      S_PREPARA:   state_d = S_GERA;
      S_GERA:      state_d = S_MOSTRA;
      S_MOSTRA:    if (fim_cnt) state_d = S_INTERVALO;
      S_INTERVALO: if (fim_cnt) state_d = ultimo ? S_ESPERA : S_MOSTRA;
      // a move arriving on the timeout cycle takes precedence
      S_ESPERA: begin
        if (jogada)       state_d = S_COMPARA;
        else if (esgotou) state_d = S_ESGOTOU;
      end
      // alvo is one-hot, so any multi-bit move can never match it
      S_COMPARA: begin
        if (jogada_q != alvo) state_d = S_PERDEU;
        else if (ultimo)      state_d = S_PROXIMA;
        else                  state_d = S_ESPERA;
      end
      S_PROXIMA: state_d = (round_q == limite) ? S_GANHOU : S_GERA;
      default:   state_d = S_INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_INICIAL;
      modo_q    <= 1'b0;
      lfsr_q    <= SEMENTE;
      round_q   <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      pressed_q <= 1'b0;
      jogada_q  <= '0;
    end else begin
      state_q   <= state_d;
      pressed_q <= |botoes;
      case (state_q)
        S_INICIAL, S_GANHOU, S_PERDEU, S_ESGOTOU: begin
          if (inicia) begin
            modo_q  <= modo;
            lfsr_q  <= SEMENTE;
            round_q <= RW'(1);
            addr_q  <= '0;
            cnt_q   <= '0;
          end
        end
        S_GERA: begin
          lfsr_q <= {lfsr_q[14:0], fb};
          addr_q <= '0;
          cnt_q  <= '0;
        end
        S_MOSTRA: cnt_q <= fim_cnt ? '0 : cnt_q + MW'(1);
        S_INTERVALO: begin
          if (fim_cnt) begin
            cnt_q <= '0;
            if (ultimo) begin
              addr_q <= '0;
              tmo_q  <= '0;
            end else begin
              addr_q <= addr_q + AW'(1);
            end
          end else begin
            cnt_q <= cnt_q + MW'(1);
          end
        end
        S_ESPERA: begin
          if (jogada) jogada_q <= botoes;
          else        tmo_q    <= tmo_q + TW'(1);
        end
        S_COMPARA: begin
          tmo_q <= '0;
          if (!ultimo) addr_q <= addr_q + AW'(1);
        end
        S_PROXIMA: if (round_q != limite) round_q <= round_q + RW'(1);
        default: ;
      endcase
    end
  end

  // sequence memory is left unreset; a new game clears it
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (inicia) begin
        for (int i = 0; i < PROFUNDIDADE; i++) mem_q[i] <= '0;
      end else if (state_q == S_GERA) begin
        mem_q[round_m1[AW-1:0]] <= elem;
      end
    end
  end

  always_comb begin
    leds = '0;
    if (state_q == S_MOSTRA)      leds = alvo;
    else if (state_q == S_ESPERA) leds = botoes;
  end

  assign ganhou    = (state_q == S_GANHOU);
  assign perdeu    = (state_q == S_PERDEU);
  assign timeout   = (state_q == S_ESGOTOU);
  assign pronto    = ganhou | perdeu | timeout;
  assign db_rodada = round_q;
  assign db_estado = state_q;
endmodule

// File: tb/tb_jogo_sequencias_param.sv
// tb/tb_jogo_sequencias_param.sv - scoreboard bench for jogo_sequencias_param
module tb_jogo_sequencias_param;
  logic       clock, reset, jogar, modo;
  logic [3:0] botoes, leds;
  logic       pronto, ganhou, perdeu, timeout;
  logic [2:0] db_rodada;
  logic [3:0] db_estado;

  jogo_sequencias_param #(
    .N_BOTOES(4), .PROFUNDIDADE(4), .TIMEOUT_CICLOS(20), .MOSTRA_CICLOS(2), .SEMENTE(16'hACE1)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .modo(modo), .botoes(botoes),
    .leds(leds), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
    .db_rodada(db_rodada), .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         kind;
    logic [3:0] val;
    logic [3:0] flags;
  } exp_t;

  localparam int K_SHOW = 0;
  localparam int K_END  = 1;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad = 0;
  logic [3:0] seq [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_show(input logic [3:0] v);
    exp_t e;
    e.kind = K_SHOW; e.val = v; e.flags = 4'b0000;
    sb_q.push_back(e);
  endtask

  // flags = {ganhou, perdeu, timeout, pronto}
  task automatic push_end(input logic [3:0] st, input logic [3:0] f);
    exp_t e;
    e.kind = K_END; e.val = st; e.flags = f;
    sb_q.push_back(e);
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget);
    int n = 0;
    while (db_estado != s && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("wait_estado", db_estado, s);
  endtask

  task automatic start_game(input logic m);
    modo  = m;
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
  endtask

  task automatic play_move(input logic [3:0] b, input int hold);
    wait_state(4'd5, 200);
    botoes = b;
    repeat (hold) @(negedge clock);
    botoes = 4'b0000;
    @(negedge clock);
  endtask

  // monitor: pops the scoreboard on every display entry and every end-of-game entry
  initial begin
    logic [3:0] prev, st, cur;
    int lit, dark;
    exp_t e;
    prev = 4'd0; cur = 4'd0; lit = 0; dark = 0;
    forever begin
      @(negedge clock);
      st = db_estado;
      if (prev == 4'd3 && st != 4'd3 && st == 4'd4) check("lit_cycles", lit, 2);
      if (prev == 4'd4 && st != 4'd4 && (st == 4'd3 || st == 4'd5)) check("dark_cycles", dark, 2);
      if (st == 4'd3 && prev != 4'd3) begin
        lit = 0;
        if (sb_q.size() == 0) check("unexpected_show", 1, 0);
        else begin
          e = sb_q.pop_front();
          check("show_kind", e.kind, K_SHOW);
          cur = e.val;
        end
      end
      if (st == 4'd4 && prev != 4'd4) dark = 0;
      if (st == 4'd3) begin
        lit++;
        check("show_leds", leds, cur);
      end
      if (st == 4'd4) begin
        dark++;
        check("dark_leds", leds, 4'b0000);
      end
      if ((st == 4'd8 || st == 4'd9 || st == 4'd10) && prev != st) begin
        if (sb_q.size() == 0) check("unexpected_end", 1, 0);
        else begin
          e = sb_q.pop_front();
          check("end_kind", e.kind, K_END);
          check("end_estado", st, e.val);
          check("end_flags", {ganhou, perdeu, timeout, pronto}, e.flags);
          check("end_leds", leds, 4'b0000);
        end
      end
      prev = st;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // LFSR from 16'hACE1: ACE1, 59C3, B387, 670F -> low byte mod 4 = 1, 3, 3, 3
    seq[0] = 4'b0010; seq[1] = 4'b1000; seq[2] = 4'b1000; seq[3] = 4'b1000;
    reset = 1'b1; jogar = 1'b0; modo = 1'b0; botoes = 4'b0000;
    repeat (2) @(negedge clock);
    check("rst_outs", {leds, pronto, ganhou, perdeu, timeout}, 8'h00);
    check("rst_rodada", db_rodada, 3'd0);
    check("rst_estado", db_estado, 4'd0);
    reset = 1'b0;
    @(negedge clock);

    // game 1: modo 0, two rounds played correctly
    push_show(seq[0]); push_show(seq[0]); push_show(seq[1]);
    push_end(4'd8, 4'b1001);
    start_game(1'b0);
    check("start_prepara", db_estado, 4'd1);
    check("start_rodada", db_rodada, 3'd1);
    @(negedge clock);
    check("start_gera", db_estado, 4'd2);
    play_move(seq[0], 1);
    play_move(seq[0], 1);
    play_move(seq[1], 1);
    wait_state(4'd8, 50);
    check("g1_rodada", db_rodada, 3'd2);

    // game 2: wrong one-hot press in round 1
    push_show(seq[0]); push_end(4'd9, 4'b0101);
    start_game(1'b0);
    check("restart_flags", {ganhou, perdeu, timeout, pronto}, 4'b0000);
    check("restart_prepara", db_estado, 4'd1);
    wait_state(4'd5, 50);
    botoes = 4'b0100;
    @(negedge clock);
    check("wrong_compara", db_estado, 4'd6);
    @(negedge clock);
    check("wrong_perdeu", perdeu, 1'b1);
    check("wrong_estado", db_estado, 4'd9);
    botoes = 4'b0000;
    @(negedge clock);

    // game 3: two buttons at once
    push_show(seq[0]); push_end(4'd9, 4'b0101);
    start_game(1'b0);
    play_move(4'b0011, 1);
    wait_state(4'd9, 10);

    // game 4: no press -> timeout after 20 cycles in ESPERA
    push_show(seq[0]); push_end(4'd10, 4'b0011);
    start_game(1'b0);
    wait_state(4'd5, 50);
    n = 0;
    while (db_estado == 4'd5 && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("espera_cycles", n, 20);
    check("tmo_estado", db_estado, 4'd10);
    check("tmo_flag", timeout, 1'b1);

    // game 5: modo 1 latched, buttons held 5 cycles, four rounds
    for (int r = 1; r <= 4; r++)
      for (int k = 0; k < r; k++) push_show(seq[k]);
    push_end(4'd8, 4'b1001);
    start_game(1'b1);
    modo = 1'b0;
    for (int r = 1; r <= 4; r++)
      for (int k = 0; k < r; k++) play_move(seq[k], 5);
    wait_state(4'd8, 50);
    check("g5_rodada", db_rodada, 3'd4);

    // game 6: reset mid-MOSTRA of round 2, together with jogar
    push_show(seq[0]); push_show(seq[0]);
    start_game(1'b0);
    play_move(seq[0], 1);
    n = 0;
    while (!(db_estado == 4'd3 && db_rodada == 3'd2) && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("mid_mostra", db_estado, 4'd3);
    reset = 1'b1; jogar = 1'b1;
    @(negedge clock);
    check("midrst_estado", db_estado, 4'd0);
    check("midrst_outs", {leds, pronto, db_rodada}, 8'h00);
    @(negedge clock);
    check("rst_over_jogar", db_estado, 4'd0);
    reset = 1'b0; jogar = 1'b0;
    @(negedge clock);
    push_show(seq[0]); push_end(4'd9, 4'b0101);
    start_game(1'b0);
    play_move(4'b0001, 1);
    wait_state(4'd9, 10);
    push_show(seq[0]);
    start_game(1'b0);
    check("replay_flags", {ganhou, perdeu, timeout, pronto}, 4'b0000);
    wait_state(4'd5, 50);

    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jogo_sequencias_param.md
JOGO_SEQUENCIAS_PARAM -- requirements
Module: jogo_sequencias_param

Interface
REQ-001 Parameters SHALL be: N_BOTOES, 4, number of buttons/LEDs (2..8).
REQ-002 Parameters SHALL be: PROFUNDIDADE, 16, maximum rounds (power of 2, 4..64).
REQ-003 Parameters SHALL be: TIMEOUT_CICLOS, 5000, cycles allowed per move.
REQ-004 Parameters SHALL be: MOSTRA_CICLOS, 500, cycles each element is lit, and also the dark gap after it.
REQ-005 Parameters SHALL be: SEMENTE, 16'hACE1, LFSR seed (non-zero).
REQ-006 Ports SHALL be: clock, in, 1, single clock; all logic rising-edge.
REQ-007 Ports SHALL be: reset, in, 1, synchronous, active-high.
REQ-008 Ports SHALL be: jogar, in, 1, start or restart a game; level sampled each cycle.
REQ-009 Ports SHALL be: modo, in, 1, 0 = PROFUNDIDADE/2 rounds, 1 = PROFUNDIDADE rounds; latched on start.
REQ-010 Ports SHALL be: botoes, in, N_BOTOES, player buttons, already synchronised and debounced.
REQ-011 Ports SHALL be: leds, out, N_BOTOES, one-hot sequence display or button echo.
REQ-012 Ports SHALL be: pronto, ganhou, perdeu, timeout, out, 1 each, end-of-game flags.
REQ-013 Ports SHALL be: db_rodada, out, clog2(PROFUNDIDADE)+1, current round (1-based).
REQ-014 Ports SHALL be: db_estado, out, 4, FSM state code.

Function
REQ-015 FSM states and codes SHALL be: INICIAL 0, PREPARA 1, GERA 2, MOSTRA 3, INTERVALO 4, ESPERA 5, COMPARA 6, PROXIMA 7, GANHOU 8, PERDEU 9, ESGOTOU 10.
REQ-016 From INICIAL, jogar=1 SHALL move to PREPARA: latch modo, load LFSR with SEMENTE, set round to 1, clear sequence memory.
REQ-017 PREPARA SHALL go to GERA, which appends one element and steps the LFSR once.
REQ-018 Element value SHALL be lfsr[7:0] mod N_BOTOES, with LFSR x^16+x^14+x^13+x^11+1 (Fibonacci, shift left).
REQ-019 Elements SHALL be stored in a PROFUNDIDADE-entry internal memory; element k is fixed for the rest of the game.
REQ-020 GERA SHALL go to MOSTRA with address 0.
REQ-021 MOSTRA SHALL last exactly MOSTRA_CICLOS cycles with leds = one-hot of element[address].
REQ-022 INTERVALO SHALL last MOSTRA_CICLOS cycles with leds = 0.
REQ-023 On leaving INTERVALO: if address = round-1, go to ESPERA with address 0; otherwise increment address and return to MOSTRA.
REQ-024 A move SHALL be the first cycle of ESPERA in which botoes != 0 after a cycle with botoes == 0; a held button SHALL NOT count twice.
REQ-025 In ESPERA, leds SHALL echo botoes.
REQ-026 A move SHALL be registered and go to COMPARA the next cycle.
REQ-027 A move with more than one bit set SHALL be a wrong move.
REQ-028 In COMPARA, a wrong move SHALL go to PERDEU.
REQ-029 In COMPARA, a correct move with address < round-1 SHALL increment address and return to ESPERA.
REQ-030 In COMPARA, a correct move with address = round-1 SHALL go to PROXIMA.
REQ-031 PROXIMA SHALL go to GANHOU if round = limit (limit = PROFUNDIDADE when modo latched 1, else PROFUNDIDADE/2); otherwise increment round and go to GERA.
REQ-032 The timeout counter SHALL clear on entry to ESPERA and after every accepted move, and SHALL count each cycle spent in ESPERA.
REQ-033 When the timeout counter reaches TIMEOUT_CICLOS-1 with no move, the FSM SHALL go to ESGOTOU.
REQ-034 If a move arrives in the same cycle as the timeout condition, the move SHALL win.
REQ-035 GANHOU, PERDEU and ESGOTOU SHALL hold their flag high, plus pronto=1 and leds=0, until jogar=1.
REQ-036 jogar=1 in any of those three states SHALL clear the flags and go directly to PREPARA; in all other states jogar SHALL be ignored.
REQ-037 At most one of ganhou/perdeu/timeout SHALL be high at any time.

Reset
REQ-038 reset=1 at a clock edge SHALL force INICIAL from any state, including mid-MOSTRA or mid-ESPERA.
REQ-039 Reset values SHALL be: leds=0, pronto=0, ganhou=0, perdeu=0, timeout=0, db_rodada=0, db_estado=0.
REQ-040 Reset SHALL also clear the LFSR to SEMENTE, all counters to 0, and the move-edge history to "released"; memory contents are don't-care.
REQ-041 reset SHALL take priority over jogar.

Verification (N_BOTOES=4, PROFUNDIDADE=4, TIMEOUT_CICLOS=20, MOSTRA_CICLOS=2)
REQ-042 Reset for 2 cycles -> all outputs 0 and db_estado=0; jogar=1 one cycle later -> db_estado=1 then 2.
REQ-043 modo=0, play the reference-model sequence correctly for rounds 1 and 2 -> ganhou=1 and pronto=1 after round 2; leds during MOSTRA match the model, 2 cycles lit and 2 cycles dark.
REQ-044 Round 1, press a wrong one-hot button -> perdeu=1 two cycles after the press edge, db_estado=9.
REQ-045 Round 1, press botoes=4'b0011 -> perdeu=1; in a separate run, no press for 20 cycles in ESPERA -> timeout=1, db_estado=10.
REQ-046 modo=1, press correct buttons held for 5 cycles -> each press counts once; game reaches round 4 and then ganhou=1.
REQ-047 Reset asserted mid-MOSTRA in round 2 -> INICIAL next edge; then jogar=1 with flags set -> flags cleared and the same first element as the first game is replayed.
